fib_seq_engine: RTL and testbench
=================================

# fib_seq_engine

Parametrised sequence engine that generates the n-th term of a generalised Fibonacci sequence x(k+2) = x(k+1) + x(k) from user seeds. It runs under a start/valid handshake with a clock-enable stall. The arithmetic is W bits wide, in either wrap or saturate mode, with a per-result overflow flag. It sits in the lab datapath as a self-contained sequential generator, and its result port feeds display/ALU consumers.

## Interface
- W, default 8: datapath width of terms, seeds and result.
- NW, default 6: width of the term index n and of the step counter.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  clock enable for RUN stepping; 0 freezes the engine in RUN.
- start  in  1  request; sampled only in IDLE.
- n  in  NW  index of the requested term, latched on accepted start.
- seed_a  in  W  x(0), latched on accepted start.
- seed_b  in  W  x(1), latched on accepted start.
- sat  in  1  1 = saturate on overflow, 0 = wrap modulo 2^W; latched on accepted start.
- fn  out  W  result x(n); holds until the next result.
- ovf  out  1  1 if x(n) overflowed W bits at any point in its derivation; registered with fn.
- valid  out  1  one-cycle pulse; fn/ovf are new in this cycle.
- busy  out  1  high while in RUN.

## Operation
- Reset values: state IDLE, fn=0, ovf=0, valid=0, busy=0, internal a/b/cnt/flags = 0.
- States and transitions:
  - IDLE: if start, latch a<=seed_a, b<=seed_b, tgt<=n, mode<=sat, cnt<=0, a_ov<=0, b_ov<=0, then go to RUN.
  - RUN, en=0: hold all state.
  - RUN, en=1, cnt==tgt: fn<=a, ovf<=a_ov, then go to DONE.
  - RUN, en=1, cnt!=tgt: step.
  - DONE: valid=1 for this cycle, then unconditionally go to IDLE.
- Step:
  - Compute s = a + b as a (W+1)-bit sum; c = s[W].
  - Shift: a<=b and a_ov<=b_ov; cnt<=cnt+1.
  - b<= (c && mode) ? {W{1'b1}} : s[W-1:0].
  - b_ov<= b_ov | a_ov | c.
- Invariant after k steps: a = x(k) under the selected arithmetic, and a_ov means x(k) overflowed.
- Overflow flags track each term separately. Overflow of b = x(k+1), computed while x(k) is the answer, must not set ovf.
- Saturate mode: once a term saturates, all later terms are all-ones, with their overflow flag set.
- start is ignored in RUN and DONE; no queueing.
- rst in any state returns to IDLE with reset values in the next cycle; an in-flight computation is discarded and no valid is produced.
- n=0 is legal: result seed_a, ovf=0.
- n=1 is legal: result seed_b, ovf=0.
- Seeds are never flagged as overflowed.
- valid and busy are derived from state (DONE and RUN respectively); they are registered state decodes with no combinational path from inputs.

## Timing
- Latency: start sampled at edge E0. valid is high in the cycle after edge E0+n+1+s, where s = number of RUN cycles with en=0.
- With en held at 1, valid is asserted n+1 cycles after the start edge.
- busy rises the cycle after start is accepted and falls in the same cycle valid rises.
- The earliest next start is the cycle after valid, in IDLE. Back-to-back throughput is n+3 cycles per result.
- fn/ovf change only at the edge entering DONE, and remain stable otherwise, including across reset-free IDLE periods.

## Test plan
- W=8, seeds 0/1, sat=0, n=10, en=1 -> valid 11 cycles after start, fn=55, ovf=0.
- W=8, seeds 0/1, n=13 -> fn=233, ovf=0. This checks that the overflow of x(14) is not reported.
- W=8, seeds 0/1, n=14:
  - sat=0 -> fn=121, ovf=1.
  - sat=1 -> fn=255, ovf=1.
- Lucas seeds 2/1, n=5 -> fn=11; n=0 -> fn=2, valid one cycle after start.
- Stall and ignored start: n=10 with en=0 for 3 cycles mid-RUN -> valid 14 cycles after start, fn=55. A start pulse during RUN is ignored: exactly one valid, busy never drops early.
- Reset abort: rst asserted 4 cycles into an n=20 run -> next cycle IDLE, fn=0, ovf=0, busy=0, no valid. A fresh start with n=3 (seeds 0/1) then gives fn=2.

Source files
------------

// File: rtl/fib_seq_engine.sv
// Generalised Fibonacci term generator with wrap/saturate arithmetic.
// Start/valid handshake, clock-enable stall, per-term overflow tracking.
module fib_seq_engine #(
  parameter int W  = 8,
  parameter int NW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [W-1:0]  seed_a,
  input  logic [W-1:0]  seed_b,
  input  logic          sat,
  output logic [W-1:0]  fn,
  output logic          ovf,
  output logic          valid,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [NW-1:0] cnt;
  logic [NW-1:0] tgt;
  logic          mode;
  logic          a_ov;
  logic          b_ov;
  logic [W:0]    s;
  logic          c;

  assign s = {1'b0, a} + {1'b0, b};
  assign c = s[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      tgt   <= '0;
      mode  <= 1'b0;
      a_ov  <= 1'b0;
      b_ov  <= 1'b0;
      fn    <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a     <= seed_a;
            b     <= seed_b;
            tgt   <= n;
            mode  <= sat;
            cnt   <= '0;
            a_ov  <= 1'b0;
            b_ov  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (cnt == tgt) begin
              fn    <= a;
              ovf   <= a_ov;
              busy  <= 1'b0;
              valid <= 1'b1;
              state <= DONE;
            end else begin
              // a_ov only reflects x(k); b's carry lands on the next term
              a    <= b;
              a_ov <= b_ov;
              b    <= (c && mode) ? {W{1'b1}} : s[W-1:0];
              b_ov <= b_ov | a_ov | c;
              cnt  <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: unbounded-integer reference model compared
// every cycle, plus directed runs with literal results and latencies.
module tb_fib_seq_engine;

  localparam int W  = 8;
  localparam int NW = 6;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] n = '0;
  logic [W-1:0]  seed_a = '0;
  logic [W-1:0]  seed_b = '0;
  logic          sat = 1'b0;
  logic [W-1:0]  fn;
  logic          ovf;
  logic          valid;
  logic          busy;

  fib_seq_engine #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .n(n), .seed_a(seed_a), .seed_b(seed_b), .sat(sat),
    .fn(fn), .ovf(ovf), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int bad = 0;
  int pulses = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Result from true (unbounded) sequence value
  function automatic void ref_term(input int nn, input int sa, input int sb,
                                   input int sm, output longint fv,
                                   output bit ov);
    longint x0, x1, t;
    x0 = sa;
    x1 = sb;
    for (int i = 0; i < nn; i++) begin
      t  = x0 + x1;
      x0 = x1;
      x1 = t;
    end
    ov = (x0 > MAXV);
    if (sm != 0) fv = ov ? MAXV : x0;
    else fv = x0 & MAXV;
  endfunction

  logic [W-1:0] m_fn = '0;
  bit   m_ovf = 1'b0, m_valid = 1'b0, m_busy = 1'b0;
  longint p_fn;
  bit   p_ovf;
  int   left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_fn = '0; m_ovf = 0; m_valid = 0; m_busy = 0;
    end else if (m_valid) begin
      m_valid = 0;
    end else if (m_busy) begin
      if (en) begin
        if (left == 0) begin
          m_busy = 0; m_valid = 1;
          m_fn = p_fn[W-1:0]; m_ovf = p_ovf;
        end else left--;
      end
    end else if (start) begin
      ref_term(int'(n), int'(seed_a), int'(seed_b), int'(sat), p_fn, p_ovf);
      left = int'(n);
      m_busy = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", valid, m_valid);
      chk("busy", busy, m_busy);
      chk("fn", fn, m_fn);
      chk("ovf", ovf, m_ovf);
      if (valid) pulses++;
    end
  end

  task automatic run(input int nn, input int sa, input int sb, input int sm,
                     input int efn, input int eov, input int elat,
                     input int st_at, input int st_len, input int poke);
    int k;
    int p0;
    bit got;
    @(negedge clk);
    n = nn[NW-1:0]; seed_a = sa[W-1:0]; seed_b = sb[W-1:0];
    sat = sm[0]; start = 1'b1;
    p0 = pulses;
    @(posedge clk);
    k = 0;
    got = 0;
    while (!got && k < 300) begin
      @(negedge clk);
      start = (k + 1 == poke);
      en = !(k + 1 >= st_at && k + 1 < st_at + st_len);
      @(posedge clk);
      k++;
      #1;
      if (valid) got = 1;
      else if (!busy) begin
        bad++; cmp++;
        $display("FAIL busy_early n=%0d: got busy 0 expected 1 at edge %0d", nn, k);
      end
    end
    chk("timeout", got, 1);
    chk("latency", k, elat);
    chk("lit_fn", fn, efn);
    chk("lit_ovf", ovf, eov);
    chk("busy_at_valid", busy, 0);
    @(negedge clk);
    start = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_valid", valid, 0);
    @(negedge clk);
    chk("pulse_count", pulses - p0, 1);
  endtask

  initial begin
    int p0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_fn", fn, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;

    run(10, 0, 1, 0, 55, 0, 11, 0, 0, 0);
    run(13, 0, 1, 0, 233, 0, 14, 0, 0, 0);
    run(14, 0, 1, 0, 121, 1, 15, 0, 0, 0);
    run(14, 0, 1, 1, 255, 1, 15, 0, 0, 0);
    run(5, 2, 1, 0, 11, 0, 6, 0, 0, 0);
    run(0, 2, 1, 0, 2, 0, 1, 0, 0, 0);
    run(1, 7, 9, 0, 9, 0, 2, 0, 0, 0);
    run(1, 200, 255, 1, 255, 0, 2, 0, 0, 0);
    run(2, 200, 100, 0, 44, 1, 3, 0, 0, 0);
    run(3, 200, 100, 1, 255, 1, 4, 0, 0, 0);
    run(20, 1, 1, 1, 255, 1, 21, 0, 0, 0);
    run(10, 0, 1, 0, 55, 0, 14, 4, 3, 2);

    @(negedge clk);
    n = 6'd20; seed_a = 8'd0; seed_b = 8'd1; sat = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    p0 = pulses;
    @(posedge clk);
    #1;
    chk("abort_fn", fn, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("abort_no_valid", pulses - p0, 0);

    run(3, 0, 1, 0, 2, 0, 4, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
